// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_if
// Description : Bundles the scanned display bus and the decoded time outputs
//               of seg_scan_decoder.
//               master : drives anode_active/segments and reads the results
//                        (a scan source or a testbench).
//               slave  : the decoder itself.
//               Signals:
//                 anode_active[3:0] active-low digit select, [3]=H1 ... [0]=M2
//                 segments[6:0]     active-low segments, [0]=a ... [6]=g
//                 h1[1:0] h2[3:0]   decoded hours tens / units
//                 m1[2:0] m2[3:0]   decoded minutes tens / units
//                 frame_valid       one-cycle pulse when h1..m2 update
//                 decode_err        error flag of the last completed frame
//                 blank             scan activity lost
//               Optional (macro SEG_SCAN_DP_EN):
//                 dp                active-low decimal point, taken with H2
//                 colon             published decimal point state
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_decoder_if;
    logic [3:0] anode_active;
    logic [6:0] segments;
    logic [1:0] h1;
    logic [3:0] h2;
    logic [2:0] m1;
    logic [3:0] m2;
    logic       frame_valid;
    logic       decode_err;
    logic       blank;
`ifdef SEG_SCAN_DP_EN
    logic       dp;
    logic       colon;

    modport master (
        output anode_active, segments, dp,
        input  h1, h2, m1, m2, frame_valid, decode_err, blank, colon
    );
    modport slave (
        input  anode_active, segments, dp,
        output h1, h2, m1, m2, frame_valid, decode_err, blank, colon
    );
`else
    modport master (
        output anode_active, segments,
        input  h1, h2, m1, m2, frame_valid, decode_err, blank
    );
    modport slave (
        input  anode_active, segments,
        output h1, h2, m1, m2, frame_valid, decode_err, blank
    );
`endif
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Receive side of a multiplexed 4-digit 7-segment display.
//               Watches the scanned anode/segment bus, waits for each digit
//               select to settle, samples and decodes the digit into its
//               H1 H2 : M1 M2 slot, and publishes the time only after the
//               same error-free frame has been seen STABLE_FRAMES times in a
//               row. Loss of scan activity for TIMEOUT cycles raises blank.
// Ports       : clk  - system clock (same domain as the scan)
//               rst  - asynchronous active-high reset
//               bus  - seg_scan_decoder_if.slave (scan inputs, decoded outputs)
// Parameters  : SETTLE        - cycles a select is held before sampling (>=1)
//               STABLE_FRAMES - identical clean frames needed to publish (>=1)
//               TIMEOUT       - idle cycles before blank asserts
// Options     : SEG_SCAN_DP_EN - adds dp input / colon output on the bus
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE        = 2,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT       = 4095
) (
    input wire              clk,
    input wire              rst,
    seg_scan_decoder_if.slave bus
);

    localparam int CNT_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int STAB_W = $clog2(STABLE_FRAMES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    // Slot index equals the anode bit position: 3=H1, 2=H2, 1=M1, 0=M2.
    localparam logic [1:0] IDX_H1 = 2'd3;
    localparam logic [1:0] IDX_M1 = 2'd1;
    localparam logic [1:0] IDX_H2 = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]        anode_q;      // last cycle's select, for change detect
    logic [CNT_W-1:0]  settle_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [3:0]        seen_mask;
    logic              frame_err;
    logic [STAB_W-1:0] stable_cnt;
    logic [3:0][3:0]   slot;         // current frame, full 4-bit decode
    logic [3:0][3:0]   prev_slot;    // previous completed frame

    // ------------------------------------------------------------------
    // Select classification
    // ------------------------------------------------------------------
    logic       sel_valid;
    logic       sel_illegal;
    logic [1:0] sel_idx;

    always_comb begin
        sel_valid   = 1'b0;
        sel_illegal = 1'b0;
        sel_idx     = 2'd0;
        case (bus.anode_active)
            4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
            4'b1111: ;                          // inter-digit gap
            default: sel_illegal = 1'b1;        // two or more digits lit
        endcase
    end

    // ------------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------------
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] seg);
        case (seg)
            7'b1000000: return 4'd0;
            7'b1111001: return 4'd1;
            7'b0100100: return 4'd2;
            7'b0110000: return 4'd3;
            7'b0011001: return 4'd4;
            7'b0010010: return 4'd5;
            7'b0000010: return 4'd6;
            7'b1111000: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0010000: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    logic [3:0] dec_val;
    logic       dec_err;
    logic       anode_changed;
    logic       take_sample;

    assign dec_val       = seg_to_bcd(bus.segments);
    assign anode_changed = (bus.anode_active != anode_q);

    // The sample is taken on the edge that moves the counter onto SETTLE,
    // so it happens exactly once per held select.
    assign take_sample = sel_valid && !anode_changed &&
                         (settle_cnt == CNT_W'(SETTLE - 1));

    // An undecodable pattern, or a tens digit out of clock range.
    assign dec_err = (dec_val == 4'hF) ||
                     ((sel_idx == IDX_H1) && (dec_val > 4'd2)) ||
                     ((sel_idx == IDX_M1) && (dec_val > 4'd5));

    // ------------------------------------------------------------------
    // Optional decimal point
    // ------------------------------------------------------------------
`ifdef SEG_SCAN_DP_EN
    logic dp_slot;
    logic prev_dp;
    logic dp_same;
    assign dp_same = (dp_slot == prev_dp);
`else
    logic dp_same;
    assign dp_same = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame qualification
    // ------------------------------------------------------------------
    logic              frame_done;
    logic              same_as_prev;
    logic [STAB_W-1:0] stable_next;
    logic              publish;
    logic              timeout_hit;

    // Completion is acted on the cycle after the fourth digit lands.
    assign frame_done   = (seen_mask == 4'b1111);
    assign same_as_prev = (slot == prev_slot) && dp_same;
    assign timeout_hit  = !take_sample && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        stable_next = stable_cnt;
        if (frame_err) begin
            stable_next = '0;
        end else if (same_as_prev) begin
            if (stable_cnt < STAB_W'(STABLE_FRAMES))
                stable_next = stable_cnt + STAB_W'(1);
        end else begin
            stable_next = STAB_W'(1);
        end
    end

    assign publish = frame_done && (stable_next == STAB_W'(STABLE_FRAMES));

    // A completing frame or a timeout starts a fresh frame; a sample or an
    // illegal select on that same cycle already belongs to the new one.
    logic [3:0] mask_base;
    logic       err_base;
    logic [3:0] mask_set;

    assign mask_base = (frame_done || timeout_hit) ? 4'b0000 : seen_mask;
    assign err_base  = (frame_done || timeout_hit) ? 1'b0    : frame_err;
    assign mask_set  = take_sample ? (4'b0001 << sel_idx) : 4'b0000;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q         <= 4'b1111;
            settle_cnt      <= '0;
            idle_cnt        <= '0;
            seen_mask       <= 4'b0000;
            frame_err       <= 1'b0;
            stable_cnt      <= '0;
            slot            <= '0;
            prev_slot       <= '0;
            bus.h1          <= 2'd0;
            bus.h2          <= 4'd0;
            bus.m1          <= 3'd0;
            bus.m2          <= 4'd0;
            bus.frame_valid <= 1'b0;
            bus.decode_err  <= 1'b0;
            bus.blank       <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_slot         <= 1'b0;
            prev_dp         <= 1'b0;
            bus.colon       <= 1'b0;
`endif
        end else begin
            anode_q <= bus.anode_active;

            // Settle counter
            if (anode_changed)
                settle_cnt <= '0;
            else if (settle_cnt != CNT_W'(SETTLE))
                settle_cnt <= settle_cnt + CNT_W'(1);

            // Activity watchdog
            if (take_sample) begin
                idle_cnt  <= '0;
                bus.blank <= 1'b0;
            end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (timeout_hit)
                    bus.blank <= 1'b1;
            end

            // Frame accumulation
            seen_mask <= mask_base | mask_set;
            frame_err <= err_base | sel_illegal | (take_sample & dec_err);
            if (take_sample)
                slot[sel_idx] <= dec_val;
`ifdef SEG_SCAN_DP_EN
            if (take_sample && (sel_idx == IDX_H2))
                dp_slot <= ~bus.dp;
`endif

            // Frame completion / qualification
            bus.frame_valid <= publish;
            if (frame_done) begin
                bus.decode_err <= frame_err;
                stable_cnt     <= stable_next;
                prev_slot      <= slot;
`ifdef SEG_SCAN_DP_EN
                prev_dp        <= dp_slot;
`endif
            end else if (timeout_hit) begin
                stable_cnt <= '0;
            end

            if (publish) begin
                bus.h1 <= slot[3][1:0];
                bus.h2 <= slot[2];
                bus.m1 <= slot[1][2:0];
                bus.m2 <= slot[0];
`ifdef SEG_SCAN_DP_EN
                bus.colon <= dp_slot;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder. A frame-level model
//               tracks how long each select has been held, what digit each
//               position last showed and how many identical clean frames
//               have been seen; one compare process checks every output on
//               every cycle, and directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int SETTLE        = 2;
    localparam int STABLE_FRAMES = 2;
    localparam int TIMEOUT       = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .SETTLE        (SETTLE),
        .STABLE_FRAMES (STABLE_FRAMES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

    int checks   = 0;
    int failures = 0;
    int fv_seen  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: positions indexed by anode bit (3=H1 .. 0=M2)
    // ------------------------------------------------------------------
    logic [3:0] m_last;
    int m_run, m_mask, m_err, m_stable, m_idle;
    int m_slot [4];
    int m_prev [4];
    int e_h1, e_h2, e_m1, e_m2, e_fv, e_err, e_blank;

    task automatic model_reset();
        m_last = 4'b1111; m_run = 0; m_mask = 0; m_err = 0; m_stable = 0; m_idle = 0;
        for (int k = 0; k < 4; k++) begin m_slot[k] = 0; m_prev[k] = 0; end
        e_h1 = 0; e_h2 = 0; e_m1 = 0; e_m2 = 0; e_fv = 0; e_err = 0; e_blank = 0;
    endtask

    task automatic model_step();
        int zeros, sel, dec;
        bit samp, serr, done, same;
        zeros = 0; sel = -1;
        for (int k = 0; k < 4; k++)
            if (!bus.anode_active[k]) begin zeros++; sel = k; end
        // hold length: number of consecutive edges the select has been seen
        if (bus.anode_active != m_last) m_run = 1; else m_run++;
        m_last = bus.anode_active;
        samp = (zeros == 1) && (m_run == SETTLE + 1);
        dec = 15;
        for (int k = 0; k < 10; k++) if (bus.segments == pat[k]) dec = k;
        serr = (dec == 15) || (sel == 3 && dec > 2) || (sel == 1 && dec > 5);
        done = (m_mask == 15);
        e_fv = 0;
        if (done) begin
            same = 1;
            for (int k = 0; k < 4; k++) if (m_slot[k] != m_prev[k]) same = 0;
            e_err = m_err;
            if (m_err != 0)  m_stable = 0;
            else if (same)   m_stable = (m_stable + 1 > STABLE_FRAMES) ? STABLE_FRAMES : m_stable + 1;
            else             m_stable = 1;
            for (int k = 0; k < 4; k++) m_prev[k] = m_slot[k];
            if (m_stable == STABLE_FRAMES) begin
                e_h1 = m_slot[3] % 4; e_h2 = m_slot[2]; e_m1 = m_slot[1] % 8; e_m2 = m_slot[0];
                e_fv = 1;
            end
            m_mask = 0; m_err = 0;
        end
        if (samp) begin
            m_idle = 0; e_blank = 0;
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                e_blank = 1;
                if (!done) begin m_stable = 0; m_mask = 0; m_err = 0; end
            end
        end
        if (zeros >= 2) m_err = 1;
        if (samp) begin
            m_slot[sel] = dec;
            m_mask = m_mask | (1 << sel);
            if (serr) m_err = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("cyc_h1", bus.h1, e_h1);
            chk("cyc_h2", bus.h2, e_h2);
            chk("cyc_m1", bus.m1, e_m1);
            chk("cyc_m2", bus.m2, e_m2);
            chk("cyc_frame_valid", bus.frame_valid, e_fv);
            chk("cyc_decode_err", bus.decode_err, e_err);
            chk("cyc_blank", bus.blank, e_blank);
            if (bus.frame_valid) fv_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (always entered and left on a negedge)
    // ------------------------------------------------------------------
    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int hold);
        bus.anode_active = an;
        bus.segments     = seg;
        repeat (hold) @(negedge clk);
    endtask

    task automatic frame_p(input logic [6:0] p3, input logic [6:0] p2,
                           input logic [6:0] p1, input logic [6:0] p0);
        show(4'b0111, p3, 4);
        show(4'b1011, p2, 4);
        show(4'b1101, p1, 4);
        show(4'b1110, p0, 4);
    endtask

    task automatic frame(input int a, input int b, input int c, input int d);
        frame_p(pat[a], pat[b], pat[c], pat[d]);
    endtask

    task automatic chk_time(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_h1"}, bus.h1, a);
        chk({tag, "_h2"}, bus.h2, b);
        chk({tag, "_m1"}, bus.m1, c);
        chk({tag, "_m2"}, bus.m2, d);
    endtask

    task automatic chk_zero(input string tag);
        chk_time(tag, 0, 0, 0, 0);
        chk({tag, "_fv"},    bus.frame_valid, 0);
        chk({tag, "_err"},   bus.decode_err, 0);
        chk({tag, "_blank"}, bus.blank, 0);
    endtask

    initial begin
        bus.anode_active = 4'b1111;
        bus.segments     = 7'h7F;
`ifdef SEG_SCAN_DP_EN
        bus.dp           = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Steady "12:34": first frame only qualifies, later frames publish.
        fv_seen = 0;
        frame(1, 2, 3, 4);
        chk("steady_f1_pulses", fv_seen, 0);
        frame(1, 2, 3, 4);
        chk("steady_f2_pulses", fv_seen, 1);
        frame(1, 2, 3, 4);
        chk("steady_f3_pulses", fv_seen, 2);
        chk_time("steady", 1, 2, 3, 4);

        // Reset part way through a frame clears everything at once.
        show(4'b0111, pat[1], 4);
        show(4'b1011, pat[2], 4);
        rst = 1'b1;
        bus.anode_active = 4'b1111;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        fv_seen = 0;
        frame(1, 2, 3, 4);
        frame(1, 2, 3, 4);
        chk("midrst_pulses", fv_seen, 1);
        chk_time("midrst", 1, 2, 3, 4);

        // Undecodable M2 pattern, then requalification on "23:59".
        fv_seen = 0;
        frame_p(pat[1], pat[2], pat[3], 7'b1111111);
        chk("illegal_err", bus.decode_err, 1);
        chk("illegal_pulses", fv_seen, 0);
        chk_time("illegal_hold", 1, 2, 3, 4);
        frame(2, 3, 5, 9);
        chk("requal_f1_err", bus.decode_err, 0);
        chk("requal_f1_pulses", fv_seen, 0);
        frame(2, 3, 5, 9);
        chk("requal_f2_pulses", fv_seen, 1);
        chk_time("requal", 2, 3, 5, 9);

        // Range errors on H1=3 and M1=7; outputs hold.
        fv_seen = 0;
        frame(3, 5, 5, 9);
        chk("range_h1_err", bus.decode_err, 1);
        frame(2, 3, 7, 9);
        chk("range_m1_err", bus.decode_err, 1);
        chk("range_pulses", fv_seen, 0);
        chk_time("range_hold", 2, 3, 5, 9);

        // One-cycle double select errors the frame.
        show(4'b0111, pat[2], 4);
        show(4'b0011, pat[8], 1);
        show(4'b1011, pat[3], 4);
        show(4'b1101, pat[5], 4);
        show(4'b1110, pat[9], 4);
        chk("glitch_err", bus.decode_err, 1);

        // A select held a single cycle is ignored; "8" must not land in M2.
        fv_seen = 0;
        show(4'b0111, pat[2], 4);
        show(4'b1011, pat[3], 4);
        show(4'b1101, pat[5], 4);
        show(4'b1110, pat[8], 1);
        show(4'b1111, 7'h7F, 6);
        chk("short_no_complete", fv_seen, 0);
        show(4'b1110, pat[9], 4);
        chk("short_err", bus.decode_err, 0);
        frame(2, 3, 5, 9);
        chk("short_pulses", fv_seen, 1);
        chk_time("short", 2, 3, 5, 9);

        // Scan loss: blank only after TIMEOUT idle cycles, outputs hold.
        show(4'b1111, 7'h7F, TIMEOUT - 10);
        chk("timeout_early_blank", bus.blank, 0);
        show(4'b1111, 7'h7F, 15);
        chk("timeout_blank", bus.blank, 1);
        chk_time("timeout_hold", 2, 3, 5, 9);
        show(4'b0111, pat[1], 4);
        chk("timeout_recover_blank", bus.blank, 0);
        show(4'b1111, 7'h7F, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver. It samples the scanned anode_active/segments bus and decodes each digit back to BCD. Digits are recovered per position as H1 H2 : M1 M2, and a frame is published only after it repeats identically. It is used as an in-system display checker and for mirroring the shown time to other logic.

Parameters:
SETTLE, 2, clk cycles a new anode select must be held before segments are sampled (the sample is taken on the cycle the counter reaches SETTLE)
STABLE_FRAMES, 2, identical consecutive error-free frames required before outputs update (at least 1)
TIMEOUT, 4095, clk cycles without any sample before blank asserts (counter width is $clog2(TIMEOUT+1))

Ports:
clk  input  1  system clock (same domain as the scan clock)
rst  input  1  asynchronous, active-high reset
anode_active  input  4  active-low digit select; [3]=H1, [2]=H2, [1]=M1, [0]=M2
segments  input  7  active-low segments; [0]=a … [6]=g
h1  output  2  decoded hours tens
h2  output  4  decoded hours units
m1  output  3  decoded minutes tens
m2  output  4  decoded minutes units
frame_valid  output  1  one-cycle pulse when h1..m2 update
decode_err  output  1  result of the last completed frame; 1 = that frame had an error
blank  output  1  scan activity lost

Behaviour:
- Reset, async, active-high: all outputs 0, and all counters, seen-mask, sample registers and previous-frame registers are cleared.
- Select classification:
  - exactly one anode bit low: a valid select for that digit.
  - 4'b1111: gap, no digit selected.
  - two or more bits low: illegal, and the current frame is marked errored.
- Settle counter: resets to 0 whenever anode_active changes. Otherwise it increments, saturating at SETTLE.
- Sampling: while a valid select is held, exactly one sample is taken when the counter reaches SETTLE. The result is stored in that digit's slot and its seen-mask bit is set.
- Decode table (segments → value, active-low, bit0=a):
  - 1000000 → 0, 1111001 → 1, 0100100 → 2, 0110000 → 3, 0011001 → 4
  - 0010010 → 5, 0000010 → 6, 1111000 → 7, 0000000 → 8, 0010000 → 9
  - Any other pattern stores 4'hF and marks the frame errored.
- Range check: H1 above 2 or M1 above 5 marks the frame errored. Stored values are truncated to port width only on publish.
- Revisiting a digit before the frame completes overwrites its slot (latest wins) and is not an error.
- Frame completion: the cycle after seen-mask reaches 4'b1111, in a single cycle:
  - decode_err is loaded with the frame's error flag, and the mask and error flag are cleared.
  - Errored frame: stable count is set to 0.
  - Error-free frame identical to the previous frame: stable count increments, saturating at STABLE_FRAMES. Otherwise it is set to 1.
  - The previous-frame registers are loaded with the current slots.
  - If stable count becomes or stays at STABLE_FRAMES, h1..m2 are loaded and frame_valid pulses. Latency is 1 cycle after the fourth sample.
- A steady display therefore produces frame_valid once per frame after qualification.
- Timeout: an idle counter clears on every sample. On reaching TIMEOUT:
  - blank=1; stable count, mask and error flag clear.
  - h1..m2 hold their values.
  - blank clears on the next sample.
- Simultaneous events: a sample on the completion cycle belongs to the new frame. A timeout on the completion cycle loses to the completion.

Optional Feature:
SEG_SCAN_DP_EN: when defined, adds a 1-bit input dp (active-low) and a 1-bit output colon.
- dp is sampled together with the H2 digit.
- colon is updated with frame_valid, resets to 0, and is included in the frame-identity comparison.
Without the macro, neither port exists and there is no DP logic.

Test Plan:
- Reset mid-frame: scan 1 2 : 3 4 and assert rst after two digits → all outputs 0 immediately; the next two full scans give frame_valid with h1=1, h2=2, m1=3, m2=4.
- Steady display "12:34" with STABLE_FRAMES=2 → no pulse after frame 1; pulse after frame 2 and every frame after.
- Illegal segment pattern 1111111 on M2 → decode_err=1 at that completion, no update; the next frame resets qualification and outputs update only after two clean frames.
- Range error: H1 pattern for 3 (0110000) → decode_err=1, outputs hold the previous value.
- Anode glitch: 4'b0011 for 1 cycle → frame errored. A select held for only 1 cycle when SETTLE=2 → not sampled.
- Timeout: hold anode_active=4'b1111 for 4095 cycles → blank=1 at cycle 4095 with outputs held; one valid sample → blank=0.
